// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and defaults for the two-master APB arbiter.
// Holds the FSM state enum, default bus widths and the timeout response word.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_STRB_W = 2;
    localparam int DEF_SEL_W  = 2;

    localparam logic [15:0] TIMEOUT_RESP = 16'hDEAD;

endpackage

// File: rtl/apb_req_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, one-hot result.
// Ports: req[1:0] requests, last_grant index of last owner, gnt[1:0] one-hot pick.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the master that did not own the bus last wins.
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-master APB arbiter (m0 SPI bridge, m1 UART debug)
// in front of a single APB slave. Whole-transfer grants, round-robin.
// Ports: clk, reset_n (async active-low); per-master APB request fields
// psel/penable/pwrite/pstrb/paddr/pwdata_mX and responses prdata/pready/
// pslverr_mX; downstream psel/penable/pwrite/pstrb/paddr/pwdata_s and
// prdata/pready/pslverr_s; grant (one-hot owner), abort_cnt (saturating).
// Optional: define ARB_TIMEOUT_EN to end a stuck access after TIMEOUT_CYC
// cycles with an arbiter-generated error response.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int STRB_W      = DEF_STRB_W,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  psel_m0,
    input  logic [SEL_W-1:0]  psel_m1,
    input  logic              penable_m0,
    input  logic              penable_m1,
    input  logic              pwrite_m0,
    input  logic              pwrite_m1,
    input  logic [STRB_W-1:0] pstrb_m0,
    input  logic [STRB_W-1:0] pstrb_m1,
    input  logic [ADDR_W-1:0] paddr_m0,
    input  logic [ADDR_W-1:0] paddr_m1,
    input  logic [DATA_W-1:0] pwdata_m0,
    input  logic [DATA_W-1:0] pwdata_m1,
    output logic [DATA_W-1:0] prdata_m0,
    output logic [DATA_W-1:0] prdata_m1,
    output logic              pready_m0,
    output logic              pready_m1,
    output logic              pslverr_m0,
    output logic              pslverr_m1,
    output logic [SEL_W-1:0]  psel_s,
    output logic              penable_s,
    output logic              pwrite_s,
    output logic [STRB_W-1:0] pstrb_s,
    output logic [ADDR_W-1:0] paddr_s,
    output logic [DATA_W-1:0] pwdata_s,
    input  logic [DATA_W-1:0] prdata_s,
    input  logic              pready_s,
    input  logic              pslverr_s,
    output logic [1:0]        grant,
    output logic [7:0]        abort_cnt
);

    arb_state_e  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic        abort_inc;
    logic [1:0]  pick;

    logic              gsel;
    logic [SEL_W-1:0]  g_psel;
    logic              g_req;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ready;
    logic              rsp_err;

    // penable_mX is not needed: ownership is decided on psel alone and the
    // downstream enable is generated from the FSM phase.
    logic unused_pen;
    assign unused_pen = penable_m0 ^ penable_m1;

    rr_pick2 u_pick (
        .req        ({|psel_m1, |psel_m0}),
        .last_grant (last_q),
        .gnt        (pick)
    );

    assign gsel   = grant_q[1];
    assign g_psel = gsel ? psel_m1 : psel_m0;
    assign g_req  = |g_psel;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q;
    logic          tmo;

    // Counts access cycles; held at zero outside ACCESS so entry starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else if (state_q != ACCESS) begin
            tcnt_q <= '0;
        end else if (tcnt_q != TW'(TIMEOUT_CYC)) begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    assign tmo = (state_q == ACCESS) && (tcnt_q == TW'(TIMEOUT_CYC));
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        abort_inc = 1'b0;
        psel_s    = '0;
        penable_s = 1'b0;
        pwrite_s  = 1'b0;
        pstrb_s   = '0;
        paddr_s   = '0;
        pwdata_s  = '0;
        rsp_rdata = '0;
        rsp_ready = 1'b0;
        rsp_err   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|pick) begin
                    grant_d = pick;
                    state_d = SETUP;
                end
            end
            SETUP, ACCESS: begin
                if (!g_req) begin
                    // Owner walked away: drop the transfer, no response.
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_d    = gsel;
                    abort_inc = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo) begin
                    rsp_rdata = DATA_W'(TIMEOUT_RESP);
                    rsp_ready = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_d    = gsel;
                    abort_inc = 1'b1;
                end
`endif
                else begin
                    psel_s   = g_psel;
                    pwrite_s = gsel ? pwrite_m1 : pwrite_m0;
                    pstrb_s  = gsel ? pstrb_m1  : pstrb_m0;
                    paddr_s  = gsel ? paddr_m1  : paddr_m0;
                    pwdata_s = gsel ? pwdata_m1 : pwdata_m0;
                    if (state_q == SETUP) begin
                        state_d = ACCESS;
                    end else begin
                        penable_s = 1'b1;
                        rsp_rdata = prdata_s;
                        rsp_ready = pready_s;
                        rsp_err   = pslverr_s & pready_s;
                        if (pready_s) begin
                            state_d = IDLE;
                            grant_d = '0;
                            last_d  = gsel;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= 1'b1;
            abort_cnt <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            if (abort_inc && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end

    assign grant = grant_q;

    // Only the owner sees the response; the other master is held stalled.
    assign prdata_m0  = gsel ? '0 : rsp_rdata;
    assign pready_m0  = ~gsel & rsp_ready;
    assign pslverr_m0 = ~gsel & rsp_err;
    assign prdata_m1  = gsel ? rsp_rdata : '0;
    assign pready_m1  = gsel & rsp_ready;
    assign pslverr_m1 = gsel & rsp_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed self-checking bench for apb_req_arbiter.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_apb_req_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  psel_m0, psel_m1;
    logic        penable_m0, penable_m1;
    logic        pwrite_m0, pwrite_m1;
    logic [1:0]  pstrb_m0, pstrb_m1;
    logic [19:0] paddr_m0, paddr_m1;
    logic [15:0] pwdata_m0, pwdata_m1;
    logic [15:0] prdata_m0, prdata_m1;
    logic        pready_m0, pready_m1;
    logic        pslverr_m0, pslverr_m1;
    logic [1:0]  psel_s;
    logic        penable_s, pwrite_s;
    logic [1:0]  pstrb_s;
    logic [19:0] paddr_s;
    logic [15:0] pwdata_s;
    logic [15:0] prdata_s;
    logic        pready_s, pslverr_s;
    logic [1:0]  grant;
    logic [7:0]  abort_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_req_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .psel_m0(psel_m0), .psel_m1(psel_m1),
        .penable_m0(penable_m0), .penable_m1(penable_m1),
        .pwrite_m0(pwrite_m0), .pwrite_m1(pwrite_m1),
        .pstrb_m0(pstrb_m0), .pstrb_m1(pstrb_m1),
        .paddr_m0(paddr_m0), .paddr_m1(paddr_m1),
        .pwdata_m0(pwdata_m0), .pwdata_m1(pwdata_m1),
        .prdata_m0(prdata_m0), .prdata_m1(prdata_m1),
        .pready_m0(pready_m0), .pready_m1(pready_m1),
        .pslverr_m0(pslverr_m0), .pslverr_m1(pslverr_m1),
        .psel_s(psel_s), .penable_s(penable_s), .pwrite_s(pwrite_s),
        .pstrb_s(pstrb_s), .paddr_s(paddr_s), .pwdata_s(pwdata_s),
        .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s),
        .grant(grant), .abort_cnt(abort_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        psel_m0 = 0; psel_m1 = 0; penable_m0 = 0; penable_m1 = 0;
        pwrite_m0 = 0; pwrite_m1 = 0; pstrb_m0 = 0; pstrb_m1 = 0;
        paddr_m0 = 0; paddr_m1 = 0; pwdata_m0 = 0; pwdata_m1 = 0;
        prdata_s = 0; pready_s = 0; pslverr_s = 0;
    endtask

    task automatic do_reset();
        nxt();
        reset_n = 0;
        idle_inputs();
        nxt();
        reset_n = 1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_psel_s"}, 32'(psel_s), 0);
        chk({tag, "_pen_s"}, 32'(penable_s), 0);
        chk({tag, "_paddr_s"}, 32'(paddr_s), 0);
        chk({tag, "_pwdata_s"}, 32'(pwdata_s), 0);
        chk({tag, "_rdy"}, 32'({pready_m1, pready_m0}), 0);
        chk({tag, "_err"}, 32'({pslverr_m1, pslverr_m0}), 0);
        chk({tag, "_rd"}, 32'({prdata_m1, prdata_m0}), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_abort"}, 32'(abort_cnt), 0);
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        #12;
        all_zero("rst");
        nxt();
        reset_n = 1;

        // m0 alone writes, slave ready on the 5th access cycle
        nxt();
        psel_m0 = 2'b01; pwrite_m0 = 1; pstrb_m0 = 2'b11;
        paddr_m0 = 20'h00123; pwdata_m0 = 16'h9432;
        #1 chk("w_idle_psel", 32'(psel_s), 0);
        nxt();
        penable_m0 = 1;
        #1;
        chk("w_setup_grant", 32'(grant), 32'h1);
        chk("w_setup_psel", 32'(psel_s), 32'h1);
        chk("w_setup_pen", 32'(penable_s), 0);
        chk("w_setup_pwdata", 32'(pwdata_s), 32'h9432);
        chk("w_setup_paddr", 32'(paddr_s), 32'h00123);
        chk("w_setup_pwrite", 32'(pwrite_s), 1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            pslverr_s = (i == 1);
            #1;
            chk("w_acc_pen", 32'(penable_s), 1);
            chk("w_acc_psel", 32'(psel_s), 32'h1);
            chk("w_acc_rdy", 32'(pready_m0), 0);
            chk("w_acc_err", 32'(pslverr_m0), 0);
        end
        nxt();
        pslverr_s = 0; pready_s = 1;
        #1 chk("w_done_rdy", 32'(pready_m0), 1);
        nxt();
        idle_inputs();
        #1;
        chk("w_after_grant", 32'(grant), 0);
        chk("w_after_psel", 32'(psel_s), 0);

        // simultaneous reads after reset: m0 first, then m1
        do_reset();
        psel_m0 = 2'b01; paddr_m0 = 20'h00332;
        psel_m1 = 2'b10; paddr_m1 = 20'h00111;
        nxt();
        penable_m0 = 1; penable_m1 = 1;
        #1;
        chk("tie_grant0", 32'(grant), 32'h1);
        chk("tie_paddr0", 32'(paddr_s), 32'h00332);
        chk("tie_pwrite0", 32'(pwrite_s), 0);
        nxt();
        pready_s = 1; prdata_s = 16'h1FA2;
        #1;
        chk("tie_rd0", 32'(prdata_m0), 32'h1FA2);
        chk("tie_rdy0", 32'(pready_m0), 1);
        chk("tie_rdy1_stall", 32'(pready_m1), 0);
        chk("tie_rd1_stall", 32'(prdata_m1), 0);
        nxt();
        psel_m0 = 0; penable_m0 = 0; pready_s = 0; prdata_s = 0;
        #1;
        chk("tie_gap_grant", 32'(grant), 0);
        chk("tie_gap_rdy1", 32'(pready_m1), 0);
        nxt();
        #1;
        chk("tie_grant1", 32'(grant), 32'h2);
        chk("tie_psel1", 32'(psel_s), 32'h2);
        chk("tie_paddr1", 32'(paddr_s), 32'h00111);
        nxt();
        pready_s = 1; prdata_s = 16'h0E33; pslverr_s = 1;
        #1;
        chk("tie_rd1", 32'(prdata_m1), 32'h0E33);
        chk("tie_rdy1", 32'(pready_m1), 1);
        chk("tie_err1", 32'(pslverr_m1), 1);
        chk("tie_rdy0_idle", 32'(pready_m0), 0);
        nxt();
        idle_inputs();

        // continuous contention: m0, m1, m0, m1
        psel_m0 = 2'b01; psel_m1 = 2'b01;
        for (int k = 0; k < 4; k++) begin
            nxt();
            #1 chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
            nxt();
            pready_s = 1;
            #1 chk("rr_rdy", 32'({pready_m1, pready_m0}),
                   (k % 2 == 0) ? 32'h1 : 32'h2);
            nxt();
            pready_s = 0;
            if (k == 3) psel_m0 = 0;
        end

        // m1 owns the bus, then abandons its access phase
        nxt();
        psel_m0 = 2'b01;
        #1 chk("ab_grant1", 32'(grant), 32'h2);
        nxt();
        #1 chk("ab_acc_pen", 32'(penable_s), 1);
        psel_m1 = 0;
        #1 chk("ab_drop_rdy", 32'(pready_m1), 0);
        nxt();
        #1;
        chk("ab_psel_s", 32'(psel_s), 0);
        chk("ab_pen_s", 32'(penable_s), 0);
        chk("ab_cnt", 32'(abort_cnt), 1);
        chk("ab_rdy1", 32'(pready_m1), 0);
        nxt();
        #1;
        chk("ab_next_grant", 32'(grant), 32'h1);
        chk("ab_next_psel", 32'(psel_s), 32'h1);
        nxt();
        pready_s = 1;
        #1 chk("ab_next_rdy", 32'(pready_m0), 1);
        nxt();
        idle_inputs();

        // reset during ACCESS clears everything immediately
        psel_m0 = 2'b01; paddr_m0 = 20'h00055;
        nxt();
        nxt();
        #1 chk("rm_acc_pen", 32'(penable_s), 1);
        #2 reset_n = 0;
        #1 all_zero("rm");
        nxt();
        psel_m1 = 2'b10;
        reset_n = 1;
        nxt();
        #1 chk("rm_first_tie", 32'(grant), 32'h1);
        nxt();
        idle_inputs();

`ifdef ARB_TIMEOUT_EN
        // slave never answers: arbiter ends the access itself
        do_reset();
        psel_m0 = 2'b01; paddr_m0 = 20'h00077;
        nxt();
        for (int i = 0; i < 8; i++) begin
            nxt();
            #1;
            chk("to_wait_pen", 32'(penable_s), 1);
            chk("to_wait_rdy", 32'(pready_m0), 0);
        end
        nxt();
        #1;
        chk("to_rdy", 32'(pready_m0), 1);
        chk("to_err", 32'(pslverr_m0), 1);
        chk("to_rd", 32'(prdata_m0), 32'hDEAD);
        chk("to_psel_s", 32'(psel_s), 0);
        chk("to_pen_s", 32'(penable_s), 0);
        nxt();
        #1 chk("to_cnt", 32'(abort_cnt), 1);
        idle_inputs();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-master APB arbiter in front of the secure FSM's single upstream APB slave port (psel_s/penable_s/... bus).
- Master 0 is the SPI slave bridge; master 1 is the UART debug bridge.
- Grants one whole transfer at a time with round-robin fairness and stalls the loser in its access phase.
- Routes the response back to the granted master only.

Parameters:
- ADDR_W, 20, APB address width.
- DATA_W, 16, APB data width.
- STRB_W, 2, write strobe width.
- SEL_W, 2, downstream select width (bit0 = register map, bit1 = interconnect).
- TIMEOUT_CYC, 64, access-phase cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- psel_m0, psel_m1  in  SEL_W  master select; non-zero = request.
- penable_m0, penable_m1  in  1  master enable.
- pwrite_m0, pwrite_m1  in  1  master write.
- pstrb_m0, pstrb_m1  in  STRB_W  master strobes.
- paddr_m0, paddr_m1  in  ADDR_W  master address.
- pwdata_m0, pwdata_m1  in  DATA_W  master write data.
- prdata_m0, prdata_m1  out  DATA_W  read data to master.
- pready_m0, pready_m1  out  1  ready to master.
- pslverr_m0, pslverr_m1  out  1  error to master.
- psel_s  out  SEL_W  select to secure FSM.
- penable_s  out  1  enable to secure FSM.
- pwrite_s  out  1  write to secure FSM.
- pstrb_s  out  STRB_W  strobes to secure FSM.
- paddr_s  out  ADDR_W  address to secure FSM.
- pwdata_s  out  DATA_W  write data to secure FSM.
- prdata_s  in  DATA_W  read data from secure FSM.
- pready_s  in  1  ready from secure FSM.
- pslverr_s  in  1  error from secure FSM.
- grant  out  2  one-hot current owner; 00 when idle.
- abort_cnt  out  8  saturating count of aborted transfers.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on reset_n.
- Reset state:
  - state = IDLE; grant = 00; last_grant = 1, so master 0 wins the first tie; abort_cnt = 0.
  - All downstream outputs = 0.
  - All prdata_mX/pready_mX/pslverr_mX = 0.
- Reset mid-transfer: immediately forces the reset state; the in-flight transfer is dropped with no response.
- Request: req_X = |psel_mX.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE:
    - Downstream psel_s = 0, penable_s = 0.
    - If exactly one req, grant it.
    - If both req, grant the master != last_grant.
    - Next state SETUP. The grant is registered.
  - SETUP:
    - Downstream psel/pwrite/pstrb/paddr/pwdata are combinationally muxed from the granted master; penable_s = 0.
    - Next state ACCESS unconditionally.
  - ACCESS:
    - Same mux; penable_s = 1.
    - pready_mG = pready_s, pslverr_mG = pslverr_s, prdata_mG = prdata_s.
    - On pready_s = 1: last_grant <= G, grant <= 00, next state IDLE.
- Non-granted master: pready/pslverr/prdata held 0, which stalls it legally in its access phase. Its request stays pending.
- Latency: a zero-wait slave completes the granted transfer 1 cycle later than a direct connection (one added wait state). Minimum 1 IDLE cycle between downstream transfers.
- Protocol abort: if the granted master drops psel to 0 in SETUP or ACCESS:
  - Go to IDLE next cycle; downstream psel_s/penable_s deasserted.
  - No response to the master; abort_cnt increments, saturating at 255.
  - last_grant is updated as if the transfer completed.
- Downstream outputs change only in SETUP; the granted master must hold its fields stable through ACCESS (APB rule).
- pslverr_s is passed only in ACCESS with pready_s; elsewhere the master sees 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro: a counter runs in ACCESS, reset on entry.
  - If pready_s has not been seen after TIMEOUT_CYC cycles, the arbiter completes the transfer itself for one cycle: pready_mG = 1, pslverr_mG = 1, prdata_mG = 16'hDEAD.
  - Downstream psel_s/penable_s drop the same cycle; next state IDLE; abort_cnt increments.
- Without the macro: ACCESS waits indefinitely for pready_s; no counter logic exists.

Decomposition:
- Package apb_arb_pkg:
  - State enum (IDLE, SETUP, ACCESS).
  - ADDR_W/DATA_W/STRB_W/SEL_W defaults.
  - TIMEOUT_RESP = 16'hDEAD.
- Sub-module rr_pick2: combinational two-way round-robin pick from req[1:0] and last_grant, returning a one-hot grant.

Test Plan:
- Master 0 alone writes paddr 20'h00123, pwdata 16'h9432, psel 01; slave pready after 5 cycles -> psel_s = 01 for SETUP + ACCESS, pwdata_s = 9432, pready_m0 on the slave-ready cycle, grant returns to 00.
- Both masters request in the same cycle after reset (m0 read 20'h00332, m1 read 20'h00111) -> m0 served first (prdata_m0 = 1FA2), then m1 (prdata_m1 = 0E33); pready_m1 stays 0 during m0's transfer.
- Both masters request continuously for 4 transfers -> grant order m0, m1, m0, m1.
- m1 drops psel during ACCESS -> psel_s = 0 next cycle, no pready_m1, abort_cnt = 1, pending m0 granted next.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, slave never ready -> after 8 ACCESS cycles: pready_m0 = 1, pslverr_m0 = 1, prdata_m0 = DEAD, abort_cnt = 1.
- reset_n asserted low in ACCESS -> all outputs 0 asynchronously; after release, master 0 wins the first tie.
